// File: rtl/return_stack_if.sv
// Bundles return_stack request and status signals; master drives requests, slave is the stack.
// Combinational pass-through only: no latency and no flow control of its own.
interface return_stack_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
);
  localparam int PW = $clog2(DEPTH);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic             clear_err;
  logic [WIDTH-1:0] top;
  logic [PW:0]      count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, data_in, clear_err,
    input  top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in, clear_err,
    output top, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_stack.sv
// Return-address LIFO with push/pop/replace-top, occupancy and sticky error flags; 1-cycle update, no stall.
// RSTACK_WRAP_EN: a push onto a full stack overwrites the oldest entry instead of being dropped.
module return_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             rst,
  return_stack_if.slave   rs
);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;
  logic [PW:0]      cnt;
  logic             ovf;
  logic             udf;

  logic [PW-1:0]    sp_m1;
  logic             is_empty;
  logic             is_full;
  logic             do_push;
  logic             do_pop;
  logic             do_repl;
  logic             wr_en;
  logic [PW-1:0]    wr_addr;

  assign sp_m1    = sp - PW'(1);
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_CNT);

  // Push+pop on an empty stack degenerates to a plain push.
  assign do_push = rs.push & (~rs.pop | is_empty);
  assign do_pop  = rs.pop & ~rs.push;
  assign do_repl = rs.push & rs.pop & ~is_empty;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sp;
    if (!rst) begin
      if (do_repl) begin
        wr_en   = 1'b1;
        wr_addr = sp_m1;
      end else if (do_push) begin
`ifdef RSTACK_WRAP_EN
        wr_en   = 1'b1;
`else
        wr_en   = ~is_full;
`endif
        wr_addr = sp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= rs.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (rs.clear_err) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end
      // Error sets below follow the clear so a same-cycle error wins.
      if (do_push) begin
        if (!is_full) begin
          sp  <= sp + PW'(1);
          cnt <= cnt + (PW+1)'(1);
        end else begin
          ovf <= 1'b1;
`ifdef RSTACK_WRAP_EN
          sp  <= sp + PW'(1);
`endif
        end
      end else if (do_pop) begin
        if (!is_empty) begin
          sp  <= sp_m1;
          cnt <= cnt - (PW+1)'(1);
        end else begin
          udf <= 1'b1;
        end
      end
    end
  end

  // Stale memory stays hidden whenever the stack is empty.
  assign rs.top       = is_empty ? '0 : mem[sp_m1];
  assign rs.count     = cnt;
  assign rs.empty     = is_empty;
  assign rs.full      = is_full;
  assign rs.overflow  = ovf;
  assign rs.underflow = udf;
endmodule

// File: tb/tb_return_stack.sv
// Directed scoreboard bench for return_stack (DEPTH=8, WIDTH=12); honours RSTACK_WRAP_EN.
module tb_return_stack;
  localparam int WIDTH = 12;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;

  typedef struct {
    string            name;
    int               cyc;
    logic [WIDTH-1:0] top;
    logic [3:0]       count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;
  } exp_t;

  exp_t exp_q[$];

  return_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) rsif ();

  return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .rs  (rsif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one request at a negedge; its effect is expected at the following negedge.
  task automatic step(input string nm, input logic pu, input logic po,
                      input logic [WIDTH-1:0] d, input logic clr, input logic r,
                      input logic [WIDTH-1:0] et, input int ec,
                      input logic eo, input logic eu);
    exp_t e;
    @(negedge clk);
    rst            = r;
    rsif.push      = pu;
    rsif.pop       = po;
    rsif.data_in   = d;
    rsif.clear_err = clr;
    e.name  = nm;
    e.cyc   = cyc + 1;
    e.top   = et;
    e.count = 4'(ec);
    e.empty = (ec == 0);
    e.full  = (ec == DEPTH);
    e.ovf   = eo;
    e.udf   = eu;
    exp_q.push_back(e);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (rsif.top !== e.top || rsif.count !== e.count || rsif.empty !== e.empty ||
            rsif.full !== e.full || rsif.overflow !== e.ovf || rsif.underflow !== e.udf) begin
          miscompares++;
          $display("FAIL %s: got top=%h cnt=%0d e=%b f=%b ov=%b un=%b, want top=%h cnt=%0d e=%b f=%b ov=%b un=%b",
                   e.name, rsif.top, rsif.count, rsif.empty, rsif.full, rsif.overflow, rsif.underflow,
                   e.top, e.count, e.empty, e.full, e.ovf, e.udf);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    rst            = 1'b1;
    rsif.push      = 1'b0;
    rsif.pop       = 1'b0;
    rsif.data_in   = '0;
    rsif.clear_err = 1'b0;

    step("reset",      0, 0, 12'h000, 0, 1, 12'h000, 0, 0, 0);
    step("push100",    1, 0, 12'h100, 0, 0, 12'h100, 1, 0, 0);
    step("push200",    1, 0, 12'h200, 0, 0, 12'h200, 2, 0, 0);
    step("push300",    1, 0, 12'h300, 0, 0, 12'h300, 3, 0, 0);
    step("pop1",       0, 1, 12'h000, 0, 0, 12'h200, 2, 0, 0);
    step("pop2",       0, 1, 12'h000, 0, 0, 12'h100, 1, 0, 0);
    step("pop3",       0, 1, 12'h000, 0, 0, 12'h000, 0, 0, 0);
    step("pop_empty",  0, 1, 12'h000, 0, 0, 12'h000, 0, 0, 1);
    step("clr_vs_pop", 0, 1, 12'h000, 1, 0, 12'h000, 0, 0, 1);
    step("clr_alone",  0, 0, 12'h000, 1, 0, 12'h000, 0, 0, 0);

    for (int i = 1; i <= DEPTH; i++)
      step($sformatf("fill%0d", i), 1, 0, 12'(i), 0, 0, 12'(i), i, 0, 0);

`ifdef RSTACK_WRAP_EN
    step("push_full",  1, 0, 12'h009, 0, 0, 12'h009, 8, 1, 0);
    for (int k = 1; k <= DEPTH; k++)
      step($sformatf("drain%0d", k), 0, 1, 12'h000, 0, 0,
           (k == DEPTH) ? 12'h000 : 12'(9 - k), DEPTH - k, 1, 0);
`else
    step("push_full",  1, 0, 12'h009, 0, 0, 12'h008, 8, 1, 0);
    for (int k = 1; k <= DEPTH; k++)
      step($sformatf("drain%0d", k), 0, 1, 12'h000, 0, 0, 12'(8 - k), DEPTH - k, 1, 0);
`endif
    step("pop9_under", 0, 1, 12'h000, 0, 0, 12'h000, 0, 1, 1);
    step("clr_both",   0, 0, 12'h000, 1, 0, 12'h000, 0, 0, 0);

    step("pushAA",     1, 0, 12'h0AA, 0, 0, 12'h0AA, 1, 0, 0);
    step("pushBB",     1, 0, 12'h0BB, 0, 0, 12'h0BB, 2, 0, 0);
    step("replCC",     1, 1, 12'h0CC, 0, 0, 12'h0CC, 2, 0, 0);
    step("popAA",      0, 1, 12'h000, 0, 0, 12'h0AA, 1, 0, 0);
    step("popEmpty2",  0, 1, 12'h000, 0, 0, 12'h000, 0, 0, 0);
    step("repl_empty", 1, 1, 12'h123, 0, 0, 12'h123, 1, 0, 0);
    step("pop123",     0, 1, 12'h000, 0, 0, 12'h000, 0, 0, 0);

    for (int i = 1; i <= 5; i++)
      step($sformatf("p5_%0d", i), 1, 0, 12'(17 * i), 0, 0, 12'(17 * i), i, 0, 0);
    step("rst_push",   1, 0, 12'h555, 0, 1, 12'h000, 0, 0, 0);
    step("push7FF",    1, 0, 12'h7FF, 0, 0, 12'h7FF, 1, 0, 0);

    for (int i = 2; i <= DEPTH; i++)
      step($sformatf("refill%0d", i), 1, 0, 12'(12'h7F0 + i), 0, 0, 12'(12'h7F0 + i), i, 0, 0);
    step("repl_full",  1, 1, 12'h555, 0, 0, 12'h555, 8, 0, 0);
    step("pop_after",  0, 1, 12'h000, 0, 0, 12'h7F7, 7, 0, 0);

    @(negedge clk);
    rsif.push      = 1'b0;
    rsif.pop       = 1'b0;
    rsif.clear_err = 1'b0;
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
